// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: 8-way round-robin arbiter driving a 3-8 decoder select, optional hold timeout via DECODER_RR_ARBITER_TIMEOUT_EN
module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic       gnt_valid_o,
  output logic       a2_o,
  output logic       a1_o,
  output logic       a0_o,
  output logic [7:0] gnt_o,
  output logic       timeout_o
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d, idx_q, idx_d, sel;
  logic       gv_q, gv_d, to_q, to_d, expire, rel;
  logic [7:0] gnt_q, gnt_d;
`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expire = cnt_q == CW'(HOLD_MAX - 1);
  // hold counter runs only while granted, so it is zero on every GRANT entry
  always_comb cnt_d = (state_q == GRANT) ? cnt_q + CW'(1) : '0;
  // hold counter register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic [7:0] unused_hold;
  assign unused_hold = 8'(HOLD_MAX);
  assign expire = 1'b0;
`endif
  assign rel = done_i | ~req_i[idx_q] | expire;
  // first requester at or above ptr, wrapping 7->0; lower k overrides so the nearest wins
  always_comb begin
    sel = ptr_q;
    for (int k = 7; k >= 0; k--)
      if (req_i[ptr_q + 3'(k)]) sel = ptr_q + 3'(k);
  end
  // next-state and registered-output logic for IDLE/GRANT/GAP
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gv_d    = gv_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: if (|req_i) begin
        state_d = GRANT;
        idx_d   = sel;
        gv_d    = 1'b1;
        gnt_d   = 8'd1 << sel;
      end
      GRANT: if (rel) begin
        state_d = GAP;
        gv_d    = 1'b0;
        gnt_d   = 8'h00;
        ptr_d   = idx_q + 3'd1;
        to_d    = expire & ~done_i & req_i[idx_q];
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      gv_q    <= 1'b0;
      gnt_q   <= 8'h00;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gv_q    <= gv_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
    end
  assign gnt_valid_o = gv_q;
  assign gnt_o       = gnt_q;
  assign {a2_o, a1_o, a0_o} = idx_q;
  assign timeout_o   = to_q;
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter: directed and random checks of decoder_rr_arbiter against a behavioural model
module tb_decoder_rr_arbiter;
  localparam int HOLD = 4;
`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       gv, a2, a1, a0, tmo;
  logic [7:0] gnt;
  int checks = 0;
  int fails = 0;
  int m_own, m_ptr, m_idx, m_held;
  bit m_gap, m_to;

  decoder_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .done_i(done),
    .gnt_valid_o(gv), .a2_o(a2), .a1_o(a1), .a0_o(a0), .gnt_o(gnt), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  wire [12:0] act = {gv, gnt, a2, a1, a0, tmo};
  wire [2:0]  idx = {a2, a1, a0};

  function automatic logic [12:0] exp_vec();
    logic [7:0] g;
    g = (m_own >= 0) ? 8'(1 << m_own) : 8'h00;
    return {m_own >= 0, g, 3'(m_idx), m_to};
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_idx = 0; m_held = 0; m_gap = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    bit limit;
    m_to = 0;
    if (m_own >= 0) begin
      limit = TO_EN && m_held == HOLD;
      if (d || !r[m_own] || limit) begin
        m_to = limit && !d && r[m_own];
        m_ptr = (m_own + 1) % 8;
        m_own = -1;
        m_gap = 1;
      end else m_held++;
    end else if (m_gap) m_gap = 0;
    else if (r != 0) begin
      for (int k = 7; k >= 0; k--) if (r[(m_ptr + k) % 8]) m_own = (m_ptr + k) % 8;
      m_idx = m_own;
      m_held = 1;
    end
  endtask

  task automatic cyc(input logic [7:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    model_edge(r, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 8'h00; done = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++; if (act !== 13'h0) begin fails++; $display("FAIL reset_init got=%h want=%h", act, 13'h0); end
    @(negedge clk); rst_n = 1'b1;
    cyc(8'hFF, 0);
    checks++; if (gnt !== 8'h01 || act !== exp_vec()) begin fails++; $display("FAIL reset_first got=%h want=%h", act, exp_vec()); end
    cyc(8'hFF, 0); cyc(8'hFF, 1); cyc(8'hFF, 0); cyc(8'hFF, 0);
    checks++; if (gnt !== 8'h02) begin fails++; $display("FAIL reset_pre gnt got=%h want=02", gnt); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (act !== 13'h0) begin fails++; $display("FAIL reset_async got=%h want=%h", act, 13'h0); end
    @(negedge clk); rst_n = 1'b1;
    cyc(8'hFF, 0);
    checks++; if (gnt !== 8'h01 || act !== exp_vec()) begin fails++; $display("FAIL reset_after got=%h want=%h", act, exp_vec()); end
  endtask

  task automatic test_single();
    do_reset();
    cyc(8'h04, 0);
    checks++; if ({gv, idx, gnt} !== {1'b1, 3'b010, 8'h04}) begin fails++; $display("FAIL single_grant got=%h want=%h", {gv, idx, gnt}, {1'b1, 3'b010, 8'h04}); end
    cyc(8'h04, 1);
    checks++; if ({gv, gnt} !== 9'h0) begin fails++; $display("FAIL single_release got=%h want=0", {gv, gnt}); end
    cyc(8'h04, 0);
    checks++; if ({gv, gnt} !== 9'h0) begin fails++; $display("FAIL single_gap got=%h want=0", {gv, gnt}); end
    cyc(8'h04, 0);
    checks++; if (act !== exp_vec() || gnt !== 8'h04) begin fails++; $display("FAIL single_regrant got=%h want=%h", act, exp_vec()); end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int n = 0; n < 10; n++) begin
      cyc(8'hFF, 0);
      checks++; if (!gv || idx !== 3'(n % 8) || act !== exp_vec()) begin fails++; $display("FAIL rotation n=%0d got=%h want_idx=%0d", n, act, n % 8); end
      cyc(8'hFF, 1);
      checks++; if (gv !== 1'b0) begin fails++; $display("FAIL rotation_gap1 n=%0d got=%b want=0", n, gv); end
      cyc(8'hFF, 0);
      checks++; if (gv !== 1'b0) begin fails++; $display("FAIL rotation_gap2 n=%0d got=%b want=0", n, gv); end
    end
  endtask

  task automatic test_sparse();
    do_reset();
    for (int n = 0; n < 4; n++) begin
      cyc(8'h81, 0);
      checks++; if (!gv || idx !== ((n % 2) ? 3'd7 : 3'd0) || act !== exp_vec()) begin fails++; $display("FAIL sparse n=%0d got=%h want=%h", n, act, exp_vec()); end
      cyc(8'h81, 1); cyc(8'h81, 0);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    cyc(8'h08, 0);
    checks++; if ({gv, idx} !== 4'b1011) begin fails++; $display("FAIL withdraw_grant got=%b want=1011", {gv, idx}); end
    cyc(8'h00, 0);
    checks++; if ({gv, tmo} !== 2'b00 || act !== exp_vec()) begin fails++; $display("FAIL withdraw_release got=%h want=%h", act, exp_vec()); end
  endtask

  task automatic test_timeout();
    do_reset();
    cyc(8'h03, 0);
    checks++; if ({gv, idx, tmo} !== 5'b10000) begin fails++; $display("FAIL timeout_grant got=%b want=10000", {gv, idx, tmo}); end
`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
    for (int n = 0; n < 3; n++) begin
      cyc(8'h03, 0);
      checks++; if ({gv, idx, tmo} !== 5'b10000) begin fails++; $display("FAIL timeout_hold n=%0d got=%b want=10000", n, {gv, idx, tmo}); end
    end
    cyc(8'h03, 0);
    checks++; if ({gv, tmo} !== 2'b01 || act !== exp_vec()) begin fails++; $display("FAIL timeout_pulse got=%b want=01", {gv, tmo}); end
    cyc(8'h03, 0);
    checks++; if ({gv, tmo} !== 2'b00) begin fails++; $display("FAIL timeout_gap got=%b want=00", {gv, tmo}); end
    cyc(8'h03, 0);
    checks++; if ({gv, idx, tmo} !== 5'b10010 || act !== exp_vec()) begin fails++; $display("FAIL timeout_next got=%b want=10010", {gv, idx, tmo}); end
`else
    for (int n = 0; n < 20; n++) begin
      cyc(8'h03, 0);
      checks++; if ({gv, idx, tmo} !== 5'b10000) begin fails++; $display("FAIL timeout_none n=%0d got=%b want=10000", n, {gv, idx, tmo}); end
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] r;
    do_reset();
    r = 8'h00;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) r = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      cyc(r, $urandom_range(0, 4) == 0);
      checks++; if (act !== exp_vec()) begin fails++; $display("FAIL random n=%0d req=%h got=%h want=%h", n, r, act, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_sparse();
    test_withdraw();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
